// File: rtl/key_entry_sequencer.sv
// -----------------------------------------------------------------------------
// key_entry_sequencer
//
// Front end of the alarm-clock keypad path. Keypad digits are debounced,
// then shifted one at a time into the 4-digit display buffer. Once a full
// entry has been keyed in, the sequencer waits for the alarm or time button
// and commits the entry with a single-cycle load strobe. An entry that sits
// idle for too long (counted in one_second ticks) is abandoned.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   one_second     in   single-cycle 1 Hz tick
//   key[3:0]       in   0-9 digit, 4'hF no key, 4'hA-4'hE treated as no key
//   alarm_button   in   level, alarm-set button
//   time_button    in   level, time-set button
//   shift          out  1-cycle pulse: shift key_digit into the display buffer
//   key_digit[3:0] out  last accepted digit (valid while shift=1)
//   load_new_a     out  1-cycle pulse: commit buffer to the alarm register
//   load_new_c     out  1-cycle pulse: commit buffer to the current-time register
//   show_a         out  level: display alarm time
//   show_new_time  out  level: display the key buffer
//   digit_count    out  digits accepted in the current entry
// -----------------------------------------------------------------------------
module key_entry_sequencer #(
    parameter int KEY_HOLD_CYCLES = 2,
    parameter int NUM_DIGITS      = 4,
    parameter int TIMEOUT_SECONDS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       shift,
    output logic [3:0] key_digit,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_a,
    output logic       show_new_time,
    output logic [2:0] digit_count
);

    localparam int HOLD_W = $clog2(KEY_HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_SECONDS + 1);

    localparam logic [HOLD_W-1:0] HOLD_TARGET   = HOLD_W'(KEY_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE      = HOLD_W'(1);
    localparam logic [TO_W-1:0]   TO_TARGET     = TO_W'(TIMEOUT_SECONDS);
    localparam logic [TO_W-1:0]   TO_ONE        = TO_W'(1);
    localparam logic [2:0]        DIGITS_TARGET = 3'(NUM_DIGITS);
    // With a single-sample hold the DEBOUNCE state is skipped entirely.
    localparam bit                DIRECT_ACCEPT = (KEY_HOLD_CYCLES == 32'sd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_READY    = 3'd4
    } state_t;

    state_t            state_r,     state_s;
    logic [3:0]        captured_r,  captured_s;
    logic [HOLD_W-1:0] hold_r,      hold_s;
    logic [TO_W-1:0]   timeout_r,   timeout_s;
    logic [2:0]        count_r,     count_s;
    logic [3:0]        key_digit_r, key_digit_s;
    logic              shift_r,     shift_s;
    logic              load_a_r,    load_a_s;
    logic              load_c_r,    load_c_s;
    logic              show_a_r,    show_a_s;
    logic              show_new_r,  show_new_s;

    logic              is_digit_s;
    logic              accept_s;
    logic [3:0]        accept_digit_s;

    assign is_digit_s = (key <= 4'd9);

    // State and registered-output update; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            captured_r  <= 4'd0;
            hold_r      <= '0;
            timeout_r   <= '0;
            count_r     <= 3'd0;
            key_digit_r <= 4'd0;
            shift_r     <= 1'b0;
            load_a_r    <= 1'b0;
            load_c_r    <= 1'b0;
            show_a_r    <= 1'b0;
            show_new_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            captured_r  <= captured_s;
            hold_r      <= hold_s;
            timeout_r   <= timeout_s;
            count_r     <= count_s;
            key_digit_r <= key_digit_s;
            shift_r     <= shift_s;
            load_a_r    <= load_a_s;
            load_c_r    <= load_c_s;
            show_a_r    <= show_a_s;
            show_new_r  <= show_new_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_s        = state_r;
        captured_s     = captured_r;
        hold_s         = hold_r;
        timeout_s      = timeout_r;
        count_s        = count_r;
        key_digit_s    = key_digit_r;
        shift_s        = 1'b0;
        load_a_s       = 1'b0;
        load_c_s       = 1'b0;
        accept_s       = 1'b0;
        accept_digit_s = captured_r;

        case (state_r)
            ST_IDLE: begin
                if (is_digit_s && DIRECT_ACCEPT) begin
                    accept_s       = 1'b1;
                    accept_digit_s = key;
                end else if (is_digit_s) begin
                    captured_s = key;
                    hold_s     = HOLD_ONE;
                    state_s    = ST_DEBOUNCE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_DEBOUNCE: begin
                if (key == captured_r) begin
                    hold_s = hold_r + HOLD_ONE;
                    if (hold_s >= HOLD_TARGET) begin
                        accept_s = 1'b1;
                    end else begin
                        state_s = ST_DEBOUNCE;
                    end
                end else if (count_r == 3'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ENTRY;
                end
            end

            ST_RELEASE: begin
                // The user is still holding the key, so the timeout is frozen.
                if (is_digit_s) begin
                    state_s = ST_RELEASE;
                end else if (count_r == DIGITS_TARGET) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (is_digit_s && DIRECT_ACCEPT) begin
                    accept_s       = 1'b1;
                    accept_digit_s = key;
                end else if (is_digit_s) begin
                    captured_s = key;
                    hold_s     = HOLD_ONE;
                    state_s    = ST_DEBOUNCE;
                end else if (one_second) begin
                    timeout_s = (timeout_r != TO_TARGET) ? (timeout_r + TO_ONE) : timeout_r;
                    if (timeout_s == TO_TARGET) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ENTRY;
                    end
                end else begin
                    state_s = ST_ENTRY;
                end
            end

            ST_READY: begin
                // Buttons take priority over a coincident timeout tick.
                if (alarm_button) begin
                    load_a_s = 1'b1;
                    state_s  = ST_IDLE;
                end else if (time_button) begin
                    load_c_s = 1'b1;
                    state_s  = ST_IDLE;
                end else if (one_second) begin
                    timeout_s = (timeout_r != TO_TARGET) ? (timeout_r + TO_ONE) : timeout_r;
                    if (timeout_s == TO_TARGET) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_READY;
                    end
                end else begin
                    state_s = ST_READY;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            shift_s     = 1'b1;
            key_digit_s = accept_digit_s;
            count_s     = (count_r < DIGITS_TARGET) ? (count_r + 3'd1) : count_r;
            timeout_s   = '0;
            hold_s      = '0;
            state_s     = ST_RELEASE;
        end else begin
            shift_s = 1'b0;
        end

        // Landing in IDLE always starts a fresh entry.
        if (state_s == ST_IDLE) begin
            count_s   = 3'd0;
            timeout_s = '0;
            hold_s    = '0;
        end else begin
            count_s = count_s;
        end

        show_a_s   = (state_s == ST_IDLE) ? alarm_button : 1'b0;
        show_new_s = (state_s != ST_IDLE) && (count_s != 3'd0);
    end

    assign shift         = shift_r;
    assign key_digit     = key_digit_r;
    assign load_new_a    = load_a_r;
    assign load_new_c    = load_c_r;
    assign show_a        = show_a_r;
    assign show_new_time = show_new_r;
    assign digit_count   = count_r;

endmodule
